// File: rtl/npc_pkg.sv
// Shared constants and helpers for the stage buffer.
// Sizing helpers are constant functions so they can feed localparams.
package npc_pkg;

  localparam int STALL_CNT_W = 32;

  // Pointer width never drops below one bit, even for a single-entry buffer.
  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 1) && (depth <= 64) && ((depth & (depth - 1)) == 0);
  endfunction

  typedef struct packed {
    logic flush;
    logic push;
    logic pop;
  } sb_op_t;

endpackage

// File: rtl/stage_buffer_mem.sv
// Payload storage for stage_buffer: one write port, one asynchronous read
// port, deliberately left without reset.
module stage_buffer_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stage_buffer.sv
// Valid/ready FIFO stage buffer with flush, occupancy and stall counter.
// Optional same-cycle bypass when empty: define STAGE_BUFFER_BYPASS_EN.
module stage_buffer
  import npc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  generate
    if (!depth_ok(DEPTH)) begin : g_depth_err
      $error("stage_buffer: DEPTH must be a power of two in 1..64");
    end
  endgenerate

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic [WIDTH-1:0]       rd_data;
  logic                   mem_vld;
  logic                   byp;
  sb_op_t                 op;

  // Head of storage is only visible when not being flushed this cycle.
  assign mem_vld = (count_q != '0) & ~flush;

`ifdef STAGE_BUFFER_BYPASS_EN
  assign byp = (count_q == '0) & s_valid & m_ready & ~flush & rst;
`else
  assign byp = 1'b0;
`endif

  assign s_ready = (count_q < FULL) & ~flush & rst;
  assign m_valid = mem_vld | byp;
  assign m_data  = byp ? s_data : (mem_vld ? rd_data : '0);

  // A bypassed payload is consumed directly and never touches storage.
  assign op = '{flush: flush,
                push:  s_valid & s_ready & ~byp,
                pop:   mem_vld & m_ready};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (m_valid && !m_ready && stall_q != '1) stall_d = stall_q + 1'b1;
    if (op.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (op.push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (op.pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({op.push, op.pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  stage_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (op.push & ~op.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign count     = count_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_stage_buffer.sv
// Directed bench for stage_buffer (WIDTH=32, DEPTH=4) with a queue model
// checked every cycle plus hand-computed literal expectations.
module tb_stage_buffer;

  localparam int D = 4;
`ifdef STAGE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, m_valid;
  logic [31:0] m_data, stall_cnt;
  logic [2:0]  count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mq[$];
  logic [31:0] mst = '0;

  always #5 clk = ~clk;

  stage_buffer #(.WIDTH(32), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .flush     (flush),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_byp();
    return BYP && rst && mq.size() == 0 && s_valid && m_ready && !flush;
  endfunction

  function automatic bit exp_mv();
    return (mq.size() != 0 && !flush) || exp_byp();
  endfunction

  // Model: queue of accepted payloads, updated from the inputs seen at each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mst = '0;
    end else begin
      bit acc;
      if (exp_mv() && !m_ready && mst != 32'hFFFF_FFFF) mst = mst + 1;
      if (flush) mq.delete();
      else if (!exp_byp()) begin
        acc = s_valid && (mq.size() < D);
        if (mq.size() != 0 && m_ready) void'(mq.pop_front());
        if (acc) mq.push_back(s_data);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] emd;
    bit          emv;
    emv = exp_mv();
    if (!emv)           emd = '0;
    else if (exp_byp()) emd = s_data;
    else                emd = mq[0];
    chk("cmp_s_ready", 32'(s_ready), 32'(rst && mq.size() < D && !flush));
    chk("cmp_m_valid", 32'(m_valid), 32'(emv));
    chk("cmp_m_data",  m_data, emd);
    chk("cmp_count",   32'(count), 32'(mq.size()));
    chk("cmp_stall",   stall_cnt, mst);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_count",   32'(count), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data",  m_data, 0);
    chk("rst_stall",   stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fill to full with m_ready low; fifth push refused.
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h1111_0000 + 32'(i);
      @(negedge clk);
      chk("fill_s_ready", 32'(s_ready), (i == 5) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("fill_count", 32'(count), 4);
    chk("fill_stall", stall_cnt, 4);
    #1 m_ready = 1'b1;

    for (int k = 1; k <= 4; k++) begin
      chk("drain_m_valid", 32'(m_valid), 1);
      chk("drain_m_data",  m_data, 32'h1111_0000 + 32'(k));
      @(negedge clk);
    end
    chk("drain_count",   32'(count), 0);
    chk("drain_m_valid", 32'(m_valid), 0);
    chk("drain_stall",   stall_cnt, 4);

    // count=3, then six push+pop cycles wrap both pointers.
    #1 m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h2222_0000 + 32'(i);
      @(posedge clk); #1;
    end
    for (int j = 0; j < 6; j++) begin
      s_valid = 1'b1;
      s_data  = 32'h2222_0004 + 32'(j);
      m_ready = 1'b1;
      @(negedge clk);
      chk("pp_count",  32'(count), 3);
      chk("pp_m_data", m_data, 32'h2222_0001 + 32'(j));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pp_tail", m_data, 32'h2222_0007 + 32'(k));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pp_count_end", 32'(count), 0);
    chk("pp_stall",     stall_cnt, 6);

    // Flush at count=2 with a same-cycle push.
    #1 m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h3333_0001;
    @(posedge clk); #1;
    s_data  = 32'h3333_0002;
    @(posedge clk); #1;
    flush   = 1'b1;
    s_data  = 32'h3333_00FF;
    @(negedge clk);
    chk("fl_m_valid", 32'(m_valid), 0);
    chk("fl_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("fl_count",    32'(count), 0);
    chk("fl_m_valid2", 32'(m_valid), 0);
    #1 s_valid = 1'b1;
    s_data  = 32'h3333_0003;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("fl_next_data", m_data, 32'h3333_0003);
    chk("fl_stall",     stall_cnt, 7);
    #1 m_ready = 1'b1;
    @(posedge clk); #1;

    // Empty buffer, m_ready high: bypass vs one-cycle latency.
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
`ifdef STAGE_BUFFER_BYPASS_EN
    chk("by_m_valid", 32'(m_valid), 1);
    chk("by_m_data",  m_data, 32'hDEAD_BEEF);
    chk("by_count",   32'(count), 0);
`else
    chk("nb_m_valid", 32'(m_valid), 0);
    chk("nb_count",   32'(count), 0);
`endif
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
`ifdef STAGE_BUFFER_BYPASS_EN
    chk("by_count2",   32'(count), 0);
    chk("by_m_valid2", 32'(m_valid), 0);
`else
    chk("nb_m_valid2", 32'(m_valid), 1);
    chk("nb_m_data2",  m_data, 32'hDEAD_BEEF);
`endif
    @(posedge clk); #1;

    // Async reset with count=3, then first payload after release.
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h4444_0000 + 32'(i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("ar_count_pre", 32'(count), 3);
    chk("ar_stall_pre", stall_cnt, 9);
    #2 rst = 1'b0;
    #1;
    chk("ar_m_valid", 32'(m_valid), 0);
    chk("ar_count",   32'(count), 0);
    chk("ar_stall",   stall_cnt, 0);
    chk("ar_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h0000_00AA;
    @(negedge clk);
    chk("ar_s_ready2", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("ar_m_valid2", 32'(m_valid), 1);
    chk("ar_m_data",   m_data, 32'h0000_00AA);
    chk("ar_count2",   32'(count), 1);
    #1 m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ar_count_end", 32'(count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
